apb4_reg_bridge: RTL
====================

# apb4_reg_bridge

Parametrised APB4 completer that converts APB transfers into single-request transactions on the internal register-block bus (req / stall / ack handshake). It supersedes the fixed-width APB slave. It adds byte-strobe write masking, honoring of stall and ack, address-alignment error checking, registered responses and an optional hung-transaction timeout. It sits between the SoC APB interconnect and one generated register block.

## Interface
- ADDR_WIDTH, 8: byte-address width of paddr and bus_addr.
- DATA_WIDTH, 32: data width; one of 8/16/32/64; pstrb width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256: cycles in REQ+WAIT before forced error completion (used only with the timeout feature); ≥2.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- pstrb  in  DATA_WIDTH/8  APB write strobes.
- pready  out  1  registered transfer completion.
- prdata  out  DATA_WIDTH  registered read data.
- pslverr  out  1  registered error, valid with pready.
- bus_req  out  1  register-bus request.
- bus_req_is_wr  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  word-aligned address.
- bus_wr_data  out  DATA_WIDTH  write data.
- bus_wr_biten  out  DATA_WIDTH  bit enables, each pstrb bit replicated ×8; all zero on reads.
- bus_req_stall_wr, bus_req_stall_rd  in  1 each  register block cannot accept a request.
- bus_rd_ack, bus_wr_ack  in  1 each  completion pulses.
- bus_rd_data  in  DATA_WIDTH  read data, valid with bus_rd_ack.
- bus_rd_err, bus_wr_err  in  1 each  error, valid with the matching ack.

## Operation
- States:
  - IDLE: psel && !penable latches paddr, pwdata, pstrb and pwrite, then goes to REQ. If the address is misaligned (paddr[log2(DATA_WIDTH/8)-1:0] ≠ 0), it goes to DONE with error and issues no request.
  - REQ: bus_req=1 with the latched fields. It stays in REQ while the stall bit for its direction is set. Otherwise it goes to WAIT, or straight to DONE if the matching ack is asserted in the same cycle.
  - WAIT: bus_req=0. On the matching ack it captures bus_rd_data (reads) and the error bit, then goes to DONE.
  - DONE: pready=1 for exactly one cycle, then goes to IDLE.
- bus_* outputs are zero outside REQ. Latched fields are held stable throughout REQ.
- Ack pulses in IDLE or DONE are ignored. An ack for the wrong direction is ignored.
- psel or penable dropping mid-transfer (protocol violation) does not abort; the transfer completes normally.
- A write with pstrb=0 is still issued, with bus_wr_biten=0.
- prdata is zero for writes, errored reads and timeouts. It is held until the next DONE.
- Reset (any state): go to IDLE, all outputs 0, latches cleared. A request in flight is abandoned.

## Timing
- No-stall, ack in the REQ cycle: SETUP at cycle 0, REQ at cycle 1, DONE (pready) at cycle 2. That is one APB wait state.
- Each stall cycle adds 1; each WAIT cycle adds 1.
- Misaligned access: pready at cycle 1, with pslverr=1.
- Back-to-back: a new SETUP is accepted in the cycle after DONE. The minimum period is 3 cycles.

## Configuration
- APB4_REG_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without an ack, the bridge goes to DONE with pslverr=1 and prdata=0.
  - An ack in the expiry cycle takes priority over the timeout.
- Undefined: no counter; the bridge waits indefinitely in REQ/WAIT.

## Structure
- Package apb4_reg_bridge_pkg holds:
  - the state enum (IDLE, REQ, WAIT, DONE);
  - the function for strobe-to-bit-enable expansion;
  - the localparam for the alignment-bit count.
- Sub-module apb4_reg_bridge_timer holds the timeout counter and the expiry flag. It is instantiated only under the macro.

## Test plan
- Write 0xA5A5_1234 to 0x08 with pstrb=0xF, no stall, wr_ack in the REQ cycle:
  - bus_wr_biten=0xFFFF_FFFF, bus_addr=0x08;
  - pready at cycle 2, pslverr=0.
- Read 0x10 with stall_rd for 3 cycles, then rd_ack after 2 WAIT cycles with data 0xDEAD_BEEF:
  - bus_req held 4 cycles;
  - prdata=0xDEAD_BEEF at pready, cycle 7.
- Write with pstrb=0x5: bus_wr_biten=0x00FF_00FF. Read with any pstrb: bus_wr_biten=0.
- Read paddr=0x03: no bus_req; pready at cycle 1, pslverr=1, prdata=0.
- rd_ack with rd_err=1: pslverr=1, prdata=0. A stray wr_ack during a read is ignored.
- With the macro defined, TIMEOUT_CYCLES=8 and no ack:
  - pready with pslverr=1 after 8 REQ/WAIT cycles;
  - a late ack in IDLE is ignored.
- With the macro defined, TIMEOUT_CYCLES=8 and an ack in the expiry cycle: normal completion.
- rst_n asserted during WAIT: all outputs 0 immediately; the next transfer completes normally.

Source files
------------

// File: rtl/apb4_reg_bridge_pkg.sv
// apb4_reg_bridge_pkg: shared state encoding and helpers for the APB4 register bridge.
package apb4_reg_bridge_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
   localparam int MAX_STRB = 8;
   function automatic int align_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction
   function automatic logic [8*MAX_STRB-1:0] strb_to_biten(input logic [MAX_STRB-1:0] strb);
      logic [8*MAX_STRB-1:0] b;
      for (int i = 0; i < MAX_STRB; i++) b[i*8 +: 8] = {8{strb[i]}};
      return b;
   endfunction
endpackage

// File: rtl/apb4_reg_bridge_timer.sv
// apb4_reg_bridge_timer: hung-transaction counter; restarts from zero each time run rises.
module apb4_reg_bridge_timer #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else        cnt <= run ? cnt + 1'b1 : '0;
   assign expired = run && cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/apb4_reg_bridge.sv
// apb4_reg_bridge: APB4 completer issuing single req/stall/ack transactions to a register block.
// Optional hung-transaction timeout enabled by APB4_REG_BRIDGE_TIMEOUT_EN.
import apb4_reg_bridge_pkg::*;
module apb4_reg_bridge #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pslverr,
   output logic                    bus_req,
   output logic                    bus_req_is_wr,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH-1:0]   bus_wr_data,
   output logic [DATA_WIDTH-1:0]   bus_wr_biten,
   input  logic                    bus_req_stall_wr,
   input  logic                    bus_req_stall_rd,
   input  logic                    bus_rd_ack,
   input  logic                    bus_wr_ack,
   input  logic [DATA_WIDTH-1:0]   bus_rd_data,
   input  logic                    bus_rd_err,
   input  logic                    bus_wr_err
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int AB = align_bits(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << AB) - 1);
   state_e state, nxt;
   logic lat_wr, rsp_err, setup, mis, stall, ack, ack_err, expired, fin, fin_err;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata, rsp_data, fin_data, biten;
   logic [SW-1:0] lat_strb;
   assign setup   = psel && !penable;
   assign mis     = |(paddr & AMASK);
   assign stall   = lat_wr ? bus_req_stall_wr : bus_req_stall_rd;
   assign ack     = lat_wr ? bus_wr_ack : bus_rd_ack;
   assign ack_err = lat_wr ? bus_wr_err : bus_rd_err;
   assign biten   = DATA_WIDTH'(strb_to_biten(MAX_STRB'(lat_strb)));
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
   apb4_reg_bridge_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk(clk), .rst_n(rst_n), .run(state == REQ || state == WAIT), .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   // Ack outranks timeout; a stalled REQ never consumes an ack.
   always_comb begin
      nxt      = state;
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_data = '0;
      case (state)
         IDLE: if (setup) begin
            nxt     = mis ? DONE : REQ;
            fin     = mis;
            fin_err = mis;
         end
         REQ, WAIT: if ((state == WAIT || !stall) && ack) begin
            nxt      = DONE;
            fin      = 1'b1;
            fin_err  = ack_err;
            fin_data = (lat_wr || ack_err) ? '0 : bus_rd_data;
         end else if (expired) begin
            nxt     = DONE;
            fin     = 1'b1;
            fin_err = 1'b1;
         end else if (state == REQ && !stall) nxt = WAIT;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_strb  <= '0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (state == IDLE && setup) begin
            lat_wr    <= pwrite;
            lat_addr  <= paddr;
            lat_wdata <= pwdata;
            lat_strb  <= pstrb;
         end
         if (fin) begin
            rsp_err  <= fin_err;
            rsp_data <= fin_data;
         end
      end
   assign pready        = state == DONE;
   assign pslverr       = pready && rsp_err;
   assign prdata        = rsp_data;
   assign bus_req       = state == REQ;
   assign bus_req_is_wr = bus_req && lat_wr;
   assign bus_addr      = bus_req ? lat_addr & ~AMASK : '0;
   assign bus_wr_data   = bus_req ? lat_wdata : '0;
   assign bus_wr_biten  = bus_req_is_wr ? biten : '0;
endmodule
